// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronise, deglitch, deserialise 11-bit frames, strip F0/E0 prefixes.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       write,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          filt_clk_reg;
  logic          filt_prev_reg;
  logic [FW-1:0] filt_cnt_reg;

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          brk_reg, brk_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic [7:0]    data_reg, data_next;
  logic          write_reg, write_next;
  logic          err_reg, err_next;
`ifdef PS2_PARITY_CHECK_EN
  logic          parity_reg, parity_next;
`endif

  logic fall;
  logic sample;
  logic timeout;
  logic frame_ok;

  // Synchronisers and glitch filter; everything presets to the idle-high bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      filt_clk_reg  <= 1'b1;
      filt_prev_reg <= 1'b1;
      filt_cnt_reg  <= '0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      filt_prev_reg <= filt_clk_reg;
      if (clk_sync_reg[1] != filt_clk_reg) begin
        if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
          filt_clk_reg <= clk_sync_reg[1];
          filt_cnt_reg <= '0;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  assign fall   = filt_prev_reg & ~filt_clk_reg;
  assign sample = data_sync_reg[1];

  // Fires one count early so the registered frame_err lands TIMEOUT cycles after the last edge.
  assign timeout = (state_reg != IDLE) && !fall && (tcnt_reg == TW'(TIMEOUT - 2));

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    brk_next     = brk_reg;
    tcnt_next    = tcnt_reg;
    data_next    = data_reg;
    write_next   = 1'b0;
    err_next     = 1'b0;
    frame_ok     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_next  = parity_reg;
`endif

    if (state_reg == IDLE || fall) begin
      tcnt_next = '0;
    end else begin
      tcnt_next = tcnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (fall && !sample) begin
          state_next   = DATA;
          bit_cnt_next = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_next   = {sample, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          parity_next = sample;
`endif
          state_next = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_next = IDLE;
`ifdef PS2_PARITY_CHECK_EN
          frame_ok = sample && (^{shift_reg, parity_reg});
`else
          frame_ok = sample;
`endif
          if (!frame_ok) begin
            err_next = 1'b1;
          end else if (shift_reg == 8'hF0) begin
            brk_next = 1'b1;
          end else if (shift_reg != 8'hE0) begin
            // A code following F0 is a release and is swallowed.
            if (brk_reg) begin
              brk_next = 1'b0;
            end else begin
              data_next  = shift_reg;
              write_next = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (timeout) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'h00;
      brk_reg     <= 1'b0;
      tcnt_reg    <= '0;
      data_reg    <= 8'h00;
      write_reg   <= 1'b0;
      err_reg     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      brk_reg     <= brk_next;
      tcnt_reg    <= tcnt_next;
      data_reg    <= data_next;
      write_reg   <= write_next;
      err_reg     <= err_next;
`ifdef PS2_PARITY_CHECK_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  assign write     = write_reg;
  assign data      = data_reg;
  assign frame_err = err_reg;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed testbench for ps2_rx: make/break/extended handling, framing errors, timeout, glitches, reset.
module tb_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       write;
  logic [7:0] data;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .write(write), .data(data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (write) wr_cnt++;
      if (frame_err) err_cnt++;
      if (write && frame_err) overlap_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic ps2_bit(input logic b, input logic glitch);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    if (glitch) begin
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF / 2 - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
    if (glitch) begin
      repeat (HALF / 4) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2 - HALF / 4 - 3) @(negedge clk);
    end else begin
      repeat (HALF / 2) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_inv, input logic stop,
                            input logic glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit((~^b) ^ par_inv, glitch);
    ps2_bit(stop, glitch);
    ps2_data = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    vectors++;
    if (write !== 1'b0) begin miscompares++; $display("FAIL reset_write: got %b want 0", write); end
    vectors++;
    if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data); end
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", frame_err); end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    $display("reset: write=%b data=%h frame_err=%b", write, data, frame_err);
  endtask

  task automatic test_single_make;
    int w0 = wr_cnt, e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL single_wr: got %0d want 1", wr_cnt - w0); end
    vectors++;
    if (data !== 8'h1C) begin miscompares++; $display("FAIL single_data: got %h want 1c", data); end
    vectors++;
    if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL single_err: got %0d want 0", err_cnt - e0); end
    $display("single 1C: writes=%0d data=%h errs=%0d", wr_cnt - w0, data, err_cnt - e0);
  endtask

  task automatic test_break;
    int w0 = wr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL break_wr: got %0d want 1", wr_cnt - w0); end
    vectors++;
    if (data !== 8'h1C) begin miscompares++; $display("FAIL break_data: got %h want 1c", data); end
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (wr_cnt - w0 !== 2) begin miscompares++; $display("FAIL break_next_wr: got %0d want 2", wr_cnt - w0); end
    vectors++;
    if (data !== 8'h32) begin miscompares++; $display("FAIL break_next_data: got %h want 32", data); end
    $display("break 1C F0 1C 32: writes=%0d data=%h", wr_cnt - w0, data);
  endtask

  task automatic test_extended;
    int w0 = wr_cnt, e0 = err_cnt;
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL ext_wr: got %0d want 1", wr_cnt - w0); end
    vectors++;
    if (data !== 8'h75) begin miscompares++; $display("FAIL ext_data: got %h want 75", data); end
    vectors++;
    if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL ext_err: got %0d want 0", err_cnt - e0); end
    $display("extended E0 75 E0 F0 75: writes=%0d data=%h", wr_cnt - w0, data);
  endtask

  task automatic test_bad_stop;
    int w0, e0;
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL badstop_err: got %0d want 1", err_cnt - e0); end
    vectors++;
    if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL badstop_wr: got %0d want 0", wr_cnt - w0); end
    vectors++;
    if (data !== 8'h16) begin miscompares++; $display("FAIL badstop_data: got %h want 16", data); end
    send_frame(8'h24, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (data !== 8'h24 || wr_cnt - w0 !== 1) begin
      miscompares++; $display("FAIL badstop_recover: got data %h writes %0d want 24 / 1", data, wr_cnt - w0);
    end
    $display("bad stop then 24: errs=%0d writes=%0d data=%h", err_cnt - e0, wr_cnt - w0, data);
  endtask

  task automatic test_timeout_glitch;
    logic [7:0] b = 8'h2D;
    int first = 0, high = 0, w0;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(b[i], 1'b0);
    @(negedge clk);
    ps2_data = b[3];
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    for (int n = 1; n <= FL + 2 + TO + 20; n++) begin
      @(negedge clk);
      if (n == HALF) ps2_clk = 1'b1;
      if (frame_err) begin
        high++;
        if (first == 0) first = n;
      end
    end
    vectors++;
    if (first !== FL + 2 + TO) begin
      miscompares++; $display("FAIL timeout_cycle: got %0d want %0d", first, FL + 2 + TO);
    end
    vectors++;
    if (high !== 1) begin miscompares++; $display("FAIL timeout_width: got %0d want 1", high); end
    ps2_data = 1'b1;
    repeat (50) @(negedge clk);
    w0 = wr_cnt;
    send_frame(8'h2D, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (data !== 8'h2D || wr_cnt - w0 !== 1) begin
      miscompares++; $display("FAIL glitch_frame: got data %h writes %0d want 2d / 1", data, wr_cnt - w0);
    end
    $display("timeout at %0d cycles, glitched 2D: data=%h writes=%0d", first, data, wr_cnt - w0);
  endtask

  task automatic test_parity;
    int w0 = wr_cnt, e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    vectors++;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL parity_err: got %0d want 1", err_cnt - e0); end
    vectors++;
    if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL parity_wr: got %0d want 0", wr_cnt - w0); end
`else
    vectors++;
    if (wr_cnt - w0 !== 1 || data !== 8'h1C) begin
      miscompares++; $display("FAIL parity_ignored: got data %h writes %0d want 1c / 1", data, wr_cnt - w0);
    end
    vectors++;
    if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL parity_err: got %0d want 0", err_cnt - e0); end
`endif
    $display("inverted parity 1C: writes=%0d errs=%0d data=%h", wr_cnt - w0, err_cnt - e0, data);
  endtask

  task automatic test_reset_midframe;
    int w0, e0;
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    w0 = wr_cnt; e0 = err_cnt;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (data !== 8'h00) begin miscompares++; $display("FAIL midreset_data: got %h want 00", data); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h66, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (data !== 8'h66 || wr_cnt - w0 !== 1 || err_cnt - e0 !== 0) begin
      miscompares++;
      $display("FAIL midreset_after: got data %h writes %0d errs %0d want 66 / 1 / 0",
               data, wr_cnt - w0, err_cnt - e0);
    end
    $display("reset mid-frame then 66: data=%h writes=%0d", data, wr_cnt - w0);
  endtask

  task automatic test_back_to_back;
    int w0 = wr_cnt;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (wr_cnt - w0 !== 3 || data !== 8'h5A) begin
      miscompares++; $display("FAIL typematic: got writes %0d data %h want 3 / 5a", wr_cnt - w0, data);
    end
    vectors++;
    if (overlap_cnt !== 0) begin miscompares++; $display("FAIL overlap: got %0d want 0", overlap_cnt); end
    $display("typematic 5A x3: writes=%0d overlaps=%0d", wr_cnt - w0, overlap_cnt);
  endtask

  initial begin
    test_reset;
    test_single_make;
    test_break;
    test_extended;
    test_bad_stop;
    test_timeout_glitch;
    test_parity;
    test_reset_midframe;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
